// File: rtl/fc_buffer_sequencer.sv
// Write/read sequencer for the FC-layer input buffer (2*PE_Num single-word banks).
// Optional zero padding of the last partial row is enabled by defining FCBUF_ZERO_PAD_EN.
module fc_buffer_sequencer #(
  parameter int dwidth    = 16,
  parameter int PE_Num    = 8,
  parameter int FRAME_LEN = 400,
  parameter int RD_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [dwidth-1:0]     din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [2*PE_Num-1:0]   wdata_st,
  output logic [5:0]            buffer_waddr,
  output logic [dwidth-1:0]     buf_din,
  output logic                  buf_full,
  input  logic                  rd_start,
  output logic                  rdata_st,
  output logic [5:0]            buffer_raddr,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  rd_done
);

  localparam int NB        = 2 * PE_Num;
  localparam int BW        = (NB > 1) ? $clog2(NB) : 1;
  localparam int ROWS      = (FRAME_LEN + NB - 1) / NB;
  localparam int LAST_BANK = (FRAME_LEN - 1) % NB;

  localparam logic [BW-1:0] BANK_MAX    = BW'(NB - 1);
  localparam logic [BW-1:0] BANK_FINAL  = BW'(LAST_BANK);
  localparam logic [5:0]    ROW_FINAL   = 6'(ROWS - 1);
  localparam logic [NB-1:0] STROBE_BASE = NB'(1);

`ifdef FCBUF_ZERO_PAD_EN
  typedef enum logic [2:0] {FILL, PAD, DRAIN, FULL, READ, FLUSH} state_t;
`else
  typedef enum logic [2:0] {FILL, DRAIN, FULL, READ, FLUSH} state_t;
`endif

  state_t              state_reg, state_next;
  logic [BW-1:0]       bank_reg, bank_next;
  logic [5:0]          row_reg, row_next;
  logic [5:0]          raddr_reg, raddr_next;
  logic [NB-1:0]       wst_reg, wst_next;
  logic [5:0]          waddr_reg, waddr_next;
  logic [dwidth-1:0]   wdata_reg, wdata_next;
  logic [RD_LAT-1:0]   vld_pipe_reg;
  logic [RD_LAT-1:0]   last_pipe_reg;
  logic                done_reg;
  logic                accept;
  logic                last_beat;

  assign accept    = (state_reg == FILL) && din_valid;
  assign last_beat = (row_reg == ROW_FINAL) && (bank_reg == BANK_FINAL);

  always_comb begin
    state_next = state_reg;
    bank_next  = bank_reg;
    row_next   = row_reg;
    raddr_next = raddr_reg;
    wst_next   = '0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      FILL: begin
        if (accept) begin
          wst_next   = STROBE_BASE << bank_reg;
          waddr_next = row_reg;
          wdata_next = din;
          bank_next  = (bank_reg == BANK_MAX) ? '0 : bank_reg + 1'b1;
          if (last_beat) begin
`ifdef FCBUF_ZERO_PAD_EN
            state_next = (LAST_BANK != NB - 1) ? PAD : DRAIN;
`else
            state_next = DRAIN;
`endif
          end else if (bank_reg == BANK_MAX) begin
            row_next = row_reg + 6'd1;
          end
        end
      end
`ifdef FCBUF_ZERO_PAD_EN
      PAD: begin
        // Zero-fill the tail of the last row, one bank per cycle.
        wst_next   = STROBE_BASE << bank_reg;
        waddr_next = row_reg;
        wdata_next = '0;
        if (bank_reg == BANK_MAX) begin
          bank_next  = '0;
          state_next = DRAIN;
        end else begin
          bank_next = bank_reg + 1'b1;
        end
      end
`endif
      DRAIN: state_next = FULL;
      FULL: begin
        if (rd_start) state_next = READ;
      end
      READ: begin
        if (raddr_reg == ROW_FINAL) begin
          raddr_next = '0;
          state_next = FLUSH;
        end else begin
          raddr_next = raddr_reg + 6'd1;
        end
      end
      FLUSH: begin
        // Leave once the final row's data is on the bus; rd_done follows next cycle.
        if (last_pipe_reg[RD_LAT-1]) begin
          bank_next  = '0;
          row_next   = '0;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      bank_reg      <= '0;
      row_reg       <= '0;
      raddr_reg     <= '0;
      wst_reg       <= '0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      vld_pipe_reg  <= '0;
      last_pipe_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      bank_reg         <= bank_next;
      row_reg          <= row_next;
      raddr_reg        <= raddr_next;
      wst_reg          <= wst_next;
      waddr_reg        <= waddr_next;
      wdata_reg        <= wdata_next;
      vld_pipe_reg[0]  <= (state_reg == READ);
      last_pipe_reg[0] <= (state_reg == READ) && (raddr_reg == ROW_FINAL);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_reg[i]  <= vld_pipe_reg[i-1];
        last_pipe_reg[i] <= last_pipe_reg[i-1];
      end
      done_reg <= last_pipe_reg[RD_LAT-1];
    end
  end

  assign din_ready    = (state_reg == FILL);
  assign wdata_st     = wst_reg;
  assign buffer_waddr = waddr_reg;
  assign buf_din      = wdata_reg;
  assign buf_full     = (state_reg == FULL) || (state_reg == READ) || (state_reg == FLUSH);
  assign rdata_st     = (state_reg == READ);
  assign buffer_raddr = raddr_reg;
  assign rd_valid     = vld_pipe_reg[RD_LAT-1];
  assign rd_last      = last_pipe_reg[RD_LAT-1];
  assign rd_done      = done_reg;

endmodule

// File: tb/tb_fc_buffer_sequencer.sv
// Directed bench: a 400-word frame (PE_Num=8) and a 20-word partial-row frame.
module tb_fc_buffer_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;

  logic [15:0] din;
  logic        din_valid, din_ready, buf_full, rd_start, rdata_st, rd_valid, rd_last, rd_done;
  logic [15:0] wdata_st, buf_din;
  logic [5:0]  buffer_waddr, buffer_raddr;

  logic [15:0] b_din;
  logic        b_din_valid, b_din_ready, b_buf_full, b_rd_start, b_rdata_st, b_rd_valid, b_rd_last, b_rd_done;
  logic [15:0] b_wdata_st, b_buf_din;
  logic [5:0]  b_buffer_waddr, b_buffer_raddr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fc_buffer_sequencer #(.dwidth(16), .PE_Num(8), .FRAME_LEN(400), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .wdata_st(wdata_st), .buffer_waddr(buffer_waddr), .buf_din(buf_din), .buf_full(buf_full),
    .rd_start(rd_start), .rdata_st(rdata_st), .buffer_raddr(buffer_raddr),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_done(rd_done)
  );

  fc_buffer_sequencer #(.dwidth(16), .PE_Num(8), .FRAME_LEN(20), .RD_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .wdata_st(b_wdata_st), .buffer_waddr(b_buffer_waddr), .buf_din(b_buf_din), .buf_full(b_buf_full),
    .rd_start(b_rd_start), .rdata_st(b_rdata_st), .buffer_raddr(b_buffer_raddr),
    .rd_valid(b_rd_valid), .rd_last(b_rd_last), .rd_done(b_rd_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream one 400-word frame into dut_a; toggle=1 drops din_valid every other cycle.
  task automatic stream_a(input bit toggle);
    int  k = 0;
    int  cyc = 0;
    bit  acc;
    while (k < 400 && cyc < 2000) begin
      chk("a_din_ready_fill", din_ready, 1);
      acc       = toggle ? (cyc % 2 == 0) : 1'b1;
      din_valid = acc;
      din       = 16'(k + 1);
      rd_start  = (k == 5) || (acc && k == 399);
      step();
      if (acc) begin
        chk("a_wdata_st", wdata_st, 64'd1 << (k % 16));
        chk("a_waddr", buffer_waddr, k / 16);
        chk("a_buf_din", buf_din, k + 1);
        if (k == 16) begin
          chk("a_word17_strobe", wdata_st, 16'h0001);
          chk("a_word17_addr", buffer_waddr, 1);
        end
        if (k == 399) begin
          chk("a_word400_strobe", wdata_st, 16'h8000);
          chk("a_word400_addr", buffer_waddr, 24);
        end
        k++;
      end else begin
        chk("a_stall_no_strobe", wdata_st, 0);
      end
      cyc++;
    end
    if (k < 400) chk("a_stream_timeout", k, 400);
    din_valid = 1'b0;
    rd_start  = 1'b1;
    chk("a_ready_drop", din_ready, 0);
    chk("a_full_not_yet", buf_full, 0);
    step();
    rd_start = 1'b0;
    chk("a_full_rise", buf_full, 1);
    chk("a_ready_in_full", din_ready, 0);
    chk("a_no_strobe_full", wdata_st, 0);
    step();
    step();
    chk("a_early_rdstart_ignored", rdata_st, 0);
    chk("a_full_hold", buf_full, 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    din = '0; din_valid = 1'b0; rd_start = 1'b0;
    b_din = '0; b_din_valid = 1'b0; b_rd_start = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_din_ready", din_ready, 1);
    chk("rst_wdata_st", wdata_st, 0);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_rdata_st", rdata_st, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_b_din_ready", b_din_ready, 1);

    // Continuous frame, then full read sweep with rd_start held high.
    stream_a(1'b0);
    rd_start = 1'b1;
    step();
    for (int r = 0; r < 25; r++) begin
      chk("a_rdata_st", rdata_st, 1);
      chk("a_raddr", buffer_raddr, r);
      chk("a_rd_valid", rd_valid, (r > 0) ? 1 : 0);
      chk("a_rd_last_early", rd_last, 0);
      chk("a_buf_full_read", buf_full, 1);
      step();
    end
    chk("a_rdata_st_end", rdata_st, 0);
    chk("a_rd_valid_last", rd_valid, 1);
    chk("a_rd_last", rd_last, 1);
    chk("a_rd_done_early", rd_done, 0);
    step();
    rd_start = 1'b0;
    chk("a_rd_done", rd_done, 1);
    chk("a_rd_valid_after", rd_valid, 0);
    chk("a_ready_back", din_ready, 1);
    chk("a_full_cleared", buf_full, 0);
    step();
    chk("a_rd_done_pulse", rd_done, 0);

    // Stalling frame, then reset in the middle of the sweep.
    stream_a(1'b1);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int r = 0; r < 10; r++) step();
    chk("a_raddr_pre_reset", buffer_raddr, 10);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("a_rst_rdata_st", rdata_st, 0);
    chk("a_rst_raddr", buffer_raddr, 0);
    chk("a_rst_rd_valid", rd_valid, 0);
    chk("a_rst_buf_full", buf_full, 0);
    chk("a_rst_din_ready", din_ready, 1);
    for (int r = 0; r < 3; r++) begin
      step();
      chk("a_no_valid_after_rst", rd_valid, 0);
      chk("a_no_last_after_rst", rd_last, 0);
    end
    din_valid = 1'b1;
    din = 16'h00AA;
    step();
    din_valid = 1'b0;
    chk("a_restart_strobe", wdata_st, 16'h0001);
    chk("a_restart_addr", buffer_waddr, 0);
    chk("a_restart_data", buf_din, 16'h00AA);

    // 20-word frame: last row is partial.
    for (int k = 0; k < 20; k++) begin
      b_din_valid = 1'b1;
      b_din = 16'(k + 1);
      step();
      chk("b_wdata_st", b_wdata_st, 64'd1 << (k % 16));
      chk("b_waddr", b_buffer_waddr, k / 16);
      chk("b_buf_din", b_buf_din, k + 1);
    end
    b_din_valid = 1'b0;
    chk("b_word20_strobe", b_wdata_st, 16'h0008);
    chk("b_word20_addr", b_buffer_waddr, 1);
    chk("b_ready_drop", b_din_ready, 0);
`ifdef FCBUF_ZERO_PAD_EN
    for (int j = 0; j < 12; j++) begin
      step();
      chk("b_pad_strobe", b_wdata_st, 64'd1 << (4 + j));
      chk("b_pad_addr", b_buffer_waddr, 1);
      chk("b_pad_data", b_buf_din, 0);
      chk("b_pad_ready", b_din_ready, 0);
      chk("b_pad_not_full", b_buf_full, 0);
    end
`endif
    step();
    chk("b_full", b_buf_full, 1);
    chk("b_no_strobe_full", b_wdata_st, 0);
    b_rd_start = 1'b1;
    step();
    b_rd_start = 1'b0;
    chk("b_rdata_st0", b_rdata_st, 1);
    chk("b_raddr0", b_buffer_raddr, 0);
    step();
    chk("b_rdata_st1", b_rdata_st, 1);
    chk("b_raddr1", b_buffer_raddr, 1);
    chk("b_rd_valid0", b_rd_valid, 1);
    chk("b_rd_last0", b_rd_last, 0);
    step();
    chk("b_rdata_st_end", b_rdata_st, 0);
    chk("b_rd_valid1", b_rd_valid, 1);
    chk("b_rd_last1", b_rd_last, 1);
    step();
    chk("b_rd_done", b_rd_done, 1);
    chk("b_ready_back", b_din_ready, 1);
    chk("b_full_cleared", b_buf_full, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
